// File: rtl/pwl_pkg.sv
// pwl_pkg: shared definitions for the piecewise-linear function evaluator.
//   - cfg_sel_e        : table selector encodings for the config port
//   - DEF_*            : default sqrt table (8 segments, Q8.8) the controller
//                        loads after reset
//   - cfg_write_legal  : which (sel, addr) pairs address a real table entry
package pwl_pkg;

  typedef enum logic [1:0] {
    CFG_BP    = 2'd0,
    CFG_SLOPE = 2'd1,
    CFG_ICPT  = 2'd2,
    CFG_RSVD  = 2'd3
  } cfg_sel_e;

  localparam int DEF_N_SEG = 8;

  // Default sqrt approximation, Q8.8: N_SEG+1 breakpoints, N_SEG slopes/intercepts.
  localparam logic [15:0] DEF_BP [DEF_N_SEG+1] = '{
    16'h0003, 16'h00F7, 16'h04A9, 16'h0C03, 16'h17BF,
    16'h28A1, 16'h3F38, 16'h5BDB, 16'h7F00
  };
  localparam logic [15:0] DEF_SLOPE [DEF_N_SEG] = '{
    16'h00E2, 16'h004F, 16'h002D, 16'h001F,
    16'h0017, 16'h0012, 16'h000F, 16'h000C
  };
  localparam logic [15:0] DEF_ICPT [DEF_N_SEG] = '{
    16'h0038, 16'h00C6, 16'h0166, 16'h0214,
    16'h02CE, 16'h0393, 16'h0461, 16'h0536
  };

  // Breakpoints have N_SEG+1 entries, slopes and intercepts N_SEG.
  // Anything else (including the reserved selector) is silently dropped.
  function automatic logic cfg_write_legal(input logic [1:0] sel,
                                           input int unsigned addr,
                                           input int unsigned n_seg);
    logic ok;
    ok = 1'b0;
    case (sel)
      CFG_BP:    ok = (addr <= n_seg);
      CFG_SLOPE: ok = (addr < n_seg);
      CFG_ICPT:  ok = (addr < n_seg);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/pwl_func_eval_seg_search.sv
// pwl_func_eval_seg_search: combinational region finder.
//   x_c    in  : clamped sample
//   bp     in  : interior breakpoints bp[1..N_SEG-1]
//   region out : number of interior breakpoints <= x_c
// A population count rather than a priority encoder, so a non-monotonic
// table still yields a well-defined (count-based) region.
module pwl_func_eval_seg_search
  import pwl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_SEG  = 8,
  parameter int SEG_W  = $clog2(N_SEG)
) (
  input  logic [DATA_W-1:0] x_c,
  input  logic [DATA_W-1:0] bp [1:N_SEG-1],
  output logic [SEG_W-1:0]  region
);

  logic [N_SEG-1:1] ge;

  always_comb begin
    ge     = '0;
    region = '0;
    for (int k = 1; k < N_SEG; k++) begin
      ge[k] = (bp[k] <= x_c);
    end
    for (int k = 1; k < N_SEG; k++) begin
      region = region + SEG_W'(ge[k]);
    end
  end

endmodule

// File: rtl/pwl_func_eval.sv
// pwl_func_eval: y = slope[r]*x + intercept[r] over a programmable
// N_SEG-segment table, unsigned Q(DATA_W-FRAC_W).FRAC_W, three-stage pipeline.
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid/in_ready/x_in    : sample input
//   out_valid/out_ready       : result output
//   y_out, out_sat, out_region: result, saturation flag, segment used
//   cfg_we/cfg_ready          : table write strobe / write permitted
//   cfg_sel/cfg_addr/cfg_wdata: table select, index, data
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. Output data is held stable while out_valid & !out_ready. A
// config write transfers on cfg_we & cfg_ready; a dropped write must be
// retried by the writer.
module pwl_func_eval
  import pwl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int N_SEG  = 8,
  parameter int SEG_W  = $clog2(N_SEG),
  parameter int ADDR_W = $clog2(N_SEG + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y_out,
  output logic              out_sat,
  output logic [SEG_W-1:0]  out_region,
  input  logic              cfg_we,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_sel,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata
);

  // Product plus rounding plus intercept never exceeds 2*DATA_W+1 bits.
  localparam int PW = 2 * DATA_W + 1;

  // ---------------------------------------------------------------- tables
  logic [DATA_W-1:0] bp_q    [0:N_SEG];
  logic [DATA_W-1:0] bp_d    [0:N_SEG];
  logic [DATA_W-1:0] slope_q [0:N_SEG-1];
  logic [DATA_W-1:0] slope_d [0:N_SEG-1];
  logic [DATA_W-1:0] icpt_q  [0:N_SEG-1];
  logic [DATA_W-1:0] icpt_d  [0:N_SEG-1];

  // ------------------------------------------------------------- pipeline
  logic              v1_q, v1_d;
  logic [DATA_W-1:0] xc1_q, xc1_d;
  logic              v2_q, v2_d;
  logic [DATA_W-1:0] xc2_q, xc2_d;
  logic [SEG_W-1:0]  rg2_q, rg2_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              sat_q, sat_d;
  logic [SEG_W-1:0]  rg3_q, rg3_d;

  logic              en;
  logic              cfg_accept;
  logic              in_fire;
  logic              wr_legal;
  logic [DATA_W-1:0] x_clamp;
  logic [SEG_W-1:0]  region_w;
  logic [DATA_W-1:0] bp_inner [1:N_SEG-1];
  logic [PW-1:0]     prod;
  logic [PW-1:0]     prod_rnd;
  logic [PW-1:0]     sum;

  // Global stall: everything advances together or nothing does, so a full
  // pipe holds exactly three samples under backpressure.
  assign en         = !out_valid_q || out_ready;
  // Tables only change while nothing is in flight, so every sample sees
  // one consistent table.
  assign cfg_ready  = !(v1_q || v2_q || out_valid_q);
  assign cfg_accept = cfg_we && cfg_ready;
  // A write takes priority over a sample arriving on an empty pipe.
  assign in_ready   = en && !cfg_accept;
  assign in_fire    = in_valid && in_ready;

  assign wr_legal = cfg_write_legal(cfg_sel, 32'(cfg_addr), N_SEG);

  // ------------------------------------------------------ table write path
  always_comb begin
    bp_d    = bp_q;
    slope_d = slope_q;
    icpt_d  = icpt_q;
    if (cfg_accept && wr_legal) begin
      case (cfg_sel)
        CFG_BP:    bp_d[cfg_addr] = cfg_wdata;
        CFG_SLOPE: slope_d[cfg_addr[SEG_W-1:0]] = cfg_wdata;
        CFG_ICPT:  icpt_d[cfg_addr[SEG_W-1:0]] = cfg_wdata;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= N_SEG; k++) bp_q[k] <= '0;
      for (int k = 0; k < N_SEG; k++) begin
        slope_q[k] <= '0;
        icpt_q[k]  <= '0;
      end
    end else begin
      bp_q    <= bp_d;
      slope_q <= slope_d;
      icpt_q  <= icpt_d;
    end
  end

  // ------------------------------------------------ S1: clamp to table top
  assign x_clamp = (x_in > bp_q[N_SEG]) ? bp_q[N_SEG] : x_in;

  // ------------------------------------------------ S2: region search
  always_comb begin
    for (int k = 1; k < N_SEG; k++) bp_inner[k] = bp_q[k];
  end

  pwl_func_eval_seg_search #(
    .DATA_W (DATA_W),
    .N_SEG  (N_SEG),
    .SEG_W  (SEG_W)
  ) u_seg_search (
    .x_c    (xc1_q),
    .bp     (bp_inner),
    .region (region_w)
  );

  // ------------------------------------------------ S3: multiply-add
  // Round half up by adding half an LSB before dropping FRAC_W bits
  // (FRAC_W must be at least 1).
  always_comb begin
    prod     = PW'(slope_q[rg2_q]) * PW'(xc2_q);
    prod_rnd = (prod + (PW'(1) << (FRAC_W - 1))) >> FRAC_W;
    sum      = prod_rnd + PW'(icpt_q[rg2_q]);
  end

  // ------------------------------------------------ stage next-state
  always_comb begin
    v1_d        = v1_q;
    xc1_d       = xc1_q;
    v2_d        = v2_q;
    xc2_d       = xc2_q;
    rg2_d       = rg2_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    sat_d       = sat_q;
    rg3_d       = rg3_q;
    if (en) begin
      v1_d = in_fire;
      if (in_fire) xc1_d = x_clamp;
      v2_d = v1_q;
      if (v1_q) begin
        xc2_d = xc1_q;
        rg2_d = region_w;
      end
      out_valid_d = v2_q;
      if (v2_q) begin
        rg3_d = rg2_q;
        if (|sum[PW-1:DATA_W]) begin
          y_d   = '1;
          sat_d = 1'b1;
        end else begin
          y_d   = sum[DATA_W-1:0];
          sat_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      xc1_q       <= '0;
      v2_q        <= 1'b0;
      xc2_q       <= '0;
      rg2_q       <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      sat_q       <= 1'b0;
      rg3_q       <= '0;
    end else begin
      v1_q        <= v1_d;
      xc1_q       <= xc1_d;
      v2_q        <= v2_d;
      xc2_q       <= xc2_d;
      rg2_q       <= rg2_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      sat_q       <= sat_d;
      rg3_q       <= rg3_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign y_out      = y_q;
  assign out_sat    = sat_q;
  assign out_region = rg3_q;

endmodule

// File: tb/tb_pwl_func_eval.sv
// Bench for pwl_func_eval: directed cases with known answers, randomized
// streams against a plain arithmetic model, a scoreboard queue popped by an
// independent monitor, and a one-line summary.
module tb_pwl_func_eval;
  import pwl_pkg::*;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int N_SEG  = 8;
  localparam int SEG_W  = 3;
  localparam int ADDR_W = 4;
  localparam int EXP_W  = DATA_W + 1 + SEG_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] x_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] y_out;
  logic              out_sat;
  logic [SEG_W-1:0]  out_region;
  logic              cfg_we = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_sel = '0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [DATA_W-1:0] cfg_wdata = '0;

  pwl_func_eval #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .N_SEG  (N_SEG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_in       (x_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y_out      (y_out),
    .out_sat    (out_sat),
    .out_region (out_region),
    .cfg_we     (cfg_we),
    .cfg_ready  (cfg_ready),
    .cfg_sel    (cfg_sel),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata)
  );

  // ------------------------------------------------------ clock
  always #5 clk = ~clk;

  // ------------------------------------------------------ bookkeeping
  int n_checks = 0;
  int n_pass   = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ------------------------------------------------------ reference model
  int m_bp    [N_SEG+1];
  int m_slope [N_SEG];
  int m_icpt  [N_SEG];

  task automatic model_clear();
    for (int k = 0; k <= N_SEG; k++) m_bp[k] = 0;
    for (int k = 0; k < N_SEG; k++) begin
      m_slope[k] = 0;
      m_icpt[k]  = 0;
    end
  endtask

  task automatic model_write(input int sel, input int addr, input int data);
    if (sel == 0 && addr <= N_SEG) m_bp[addr] = data;
    if (sel == 1 && addr < N_SEG)  m_slope[addr] = data;
    if (sel == 2 && addr < N_SEG)  m_icpt[addr] = data;
  endtask

  function automatic logic [EXP_W-1:0] model(input int x);
    int     xc, r;
    longint p, t, s;
    logic [DATA_W-1:0] y;
    logic   sat;
    logic [SEG_W-1:0] rg;
    xc = (x < m_bp[N_SEG]) ? x : m_bp[N_SEG];
    r = 0;
    for (int k = 1; k < N_SEG; k++) if (m_bp[k] <= xc) r++;
    p = longint'(m_slope[r]) * longint'(xc);
    t = (p + (longint'(1) << (FRAC_W - 1))) / (longint'(1) << FRAC_W);
    s = t + longint'(m_icpt[r]);
    sat = (s > 65535);
    y   = sat ? 16'hFFFF : DATA_W'(s);
    rg  = SEG_W'(r);
    return {y, sat, rg};
  endfunction

  function automatic logic [EXP_W-1:0] pack(input int y, input int sat, input int rg);
    logic [DATA_W-1:0] yy;
    logic              ss;
    logic [SEG_W-1:0]  rr;
    yy = DATA_W'(y);
    ss = sat[0];
    rr = SEG_W'(rg);
    return {yy, ss, rr};
  endfunction

  // ------------------------------------------------------ driver tasks
  // Inputs change 1 time unit after a rising edge; ready is sampled on the
  // falling edge before the edge that would accept.
  task automatic send(input logic [DATA_W-1:0] x, input logic [EXP_W-1:0] e);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    x_in     = x;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back(e);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input int sel, input int addr, input int data, input logic exp_rdy);
    cfg_we    = 1'b1;
    cfg_sel   = 2'(sel);
    cfg_addr  = ADDR_W'(addr);
    cfg_wdata = DATA_W'(data);
    @(negedge clk);
    check("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
    @(posedge clk);
    if (exp_rdy) model_write(sel, addr, data);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic load_default();
    for (int k = 0; k <= N_SEG; k++) cfg_write(0, k, int'(DEF_BP[k]), 1'b1);
    for (int k = 0; k < N_SEG; k++) cfg_write(1, k, int'(DEF_SLOPE[k]), 1'b1);
    for (int k = 0; k < N_SEG; k++) cfg_write(2, k, int'(DEF_ICPT[k]), 1'b1);
  endtask

  // ------------------------------------------------------ monitor / scoreboard
  logic             stall_prev = 1'b0;
  logic [EXP_W-1:0] held;

  always @(negedge clk) begin
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] exp;
    got = {y_out, out_sat, out_region};
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) check("stall_stable", 32'(got), 32'(held));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(got), 32'hFFFFFFFF);
        end else begin
          exp = exp_q.pop_front();
          check("y_out", 32'(got[EXP_W-1:SEG_W+1]), 32'(exp[EXP_W-1:SEG_W+1]));
          check("out_sat", 32'(got[SEG_W]), 32'(exp[SEG_W]));
          check("out_region", 32'(got[SEG_W-1:0]), 32'(exp[SEG_W-1:0]));
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = got;
    end
  end

  // ------------------------------------------------------ stimulus
  bit rand_done;

  initial begin
    int lat;
    int v;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y_out", 32'(y_out), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_out_region", 32'(out_region), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Default sqrt table, known answers and latency
    load_default();
    send(16'h0100, pack(16'h0115, 0, 1));
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    drain();
    send(16'h0400, pack(16'h0202, 0, 1));
    send(16'h8000, pack(16'h0B2A, 0, 7));
    drain();

    // Random samples on default table with random backpressure
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          v = (i % 3 == 0) ? $urandom_range(0, 16'h0400) : $urandom_range(0, 16'hFFFF);
          send(DATA_W'(v), model(v));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Random monotonic table, random samples, random backpressure
    v = 0;
    for (int k = 0; k <= N_SEG; k++) begin
      v = v + $urandom_range(1, 16'h1800);
      cfg_write(0, k, v, 1'b1);
    end
    for (int k = 0; k < N_SEG; k++) begin
      cfg_write(1, k, $urandom_range(0, 16'h0800), 1'b1);
      cfg_write(2, k, $urandom_range(0, 16'hFFFF), 1'b1);
    end
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          v = $urandom_range(0, 16'hFFFF);
          send(DATA_W'(v), model(v));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = $urandom_range(0, 1);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Backpressure: three fill the pipe, three more follow after release
    load_default();
    out_ready = 1'b0;
    send(16'h0100, pack(16'h0115, 0, 1));
    send(16'h0400, pack(16'h0202, 0, 1));
    send(16'h8000, pack(16'h0B2A, 0, 7));
    @(negedge clk);
    check("in_ready_full", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'h0000, model(0));
    send(16'h1234, model(16'h1234));
    send(16'h7000, model(16'h7000));
    drain();

    // Saturation
    cfg_write(1, 0, 16'hFFFF, 1'b1);
    cfg_write(2, 0, 16'hFFFF, 1'b1);
    cfg_write(0, 1, 16'h0100, 1'b1);
    send(16'h0002, pack(16'hFFFF, 1, 0));
    // Write while a sample is in flight is dropped
    cfg_write(1, 0, 16'h0000, 1'b0);
    drain();
    send(16'h0002, pack(16'hFFFF, 1, 0));
    drain();

    // Write and sample together on an empty pipe: write wins
    cfg_we    = 1'b1;
    cfg_sel   = 2'd2;
    cfg_addr  = '0;
    cfg_wdata = 16'h0010;
    in_valid  = 1'b1;
    x_in      = 16'h0002;
    @(negedge clk);
    check("simul_in_ready", 32'(in_ready), 32'd0);
    check("simul_cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    model_write(2, 0, 16'h0010);
    #1;
    cfg_we = 1'b0;
    send(16'h0002, pack(16'h0210, 0, 0));
    drain();

    // Reserved selector and out-of-range addresses change nothing
    cfg_write(3, 0, 16'h0000, 1'b1);
    cfg_write(1, 8, 16'h0000, 1'b1);
    cfg_write(2, 8, 16'h0000, 1'b1);
    cfg_write(0, 9, 16'h0000, 1'b1);
    send(16'h0002, pack(16'h0210, 0, 0));
    send(16'h0002, model(2));
    drain();

    // Reset with the pipe full
    out_ready = 1'b0;
    send(16'h0100, model(16'h0100));
    send(16'h0200, model(16'h0200));
    send(16'h0300, model(16'h0300));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_y_out", 32'(y_out), 32'd0);
    exp_q.delete();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(16'h0100, pack(16'h0000, 0, 7));
    drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
